// File: rtl/ifetch_queue.sv
// Instruction fetch queue: one outstanding imem request, DEPTH-entry buffer.
// Define IFQ_BYPASS_EN to forward an ack straight to decode when empty.
module ifetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0] count_q, count_nx;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_pc [DEPTH];

  logic [ADDR_W-1:0] rpc_al;
  logic ack_ok, head_valid, byp, push, pop;

  assign rpc_al = redirect_pc & ALIGN;
  assign imem_req = (state_q != S_IDLE);
  assign imem_addr = addr_q;
  assign count = count_q;

  always_comb begin
    ack_ok = (state_q == S_WAIT) && imem_ack;
    head_valid = (count_q != '0);
`ifdef IFQ_BYPASS_EN
    byp = ack_ok && !head_valid && !redirect;
`else
    byp = 1'b0;
`endif
    inst_valid = head_valid | byp;
    inst = byp ? imem_data : mem_data[rd_ptr_q];
    inst_pc = byp ? addr_q : mem_pc[rd_ptr_q];
    pop = head_valid && inst_ready && !redirect;
    // A bypassed word that decode takes this cycle never enters the buffer
    push = ack_ok && !redirect && !(byp && inst_ready);
    count_nx = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = rpc_al;
        end else if (count_q < DEPTH_C) begin
          state_d = S_WAIT;
          addr_d = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_d = rpc_al;
          state_d = imem_ack ? S_IDLE : S_DROP;
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + STEP;
          if (count_nx < DEPTH_C) begin
            addr_d = fetch_pc_q + STEP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (redirect) fetch_pc_d = rpc_al;
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      count_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q <= addr_d;
      if (redirect) begin
        count_q <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        count_q <= count_nx;
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= imem_data;
      mem_pc[wr_ptr_q] <= addr_q;
    end
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter ADDR_W, default 32: PC and instruction-memory address width.
REQ-002 Parameter DATA_W, default 32: instruction width.
REQ-003 Parameter DEPTH, default 4: queue entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 imem_req  out  1  fetch request to instruction memory.
REQ-008 imem_addr  out  ADDR_W  fetch address; bits [1:0] always 0.
REQ-009 imem_ack  in  1  memory completion; imem_data valid in this cycle.
REQ-010 imem_data  in  DATA_W  fetched instruction word.
REQ-011 redirect  in  1  branch/jump taken; flush and restart fetch.
REQ-012 redirect_pc  in  ADDR_W  restart address; bits [1:0] ignored (treated as 0).
REQ-013 inst_valid  out  1  head entry valid toward decode.
REQ-014 inst_ready  in  1  decode accepts head entry.
REQ-015 inst  out  DATA_W  head instruction.
REQ-016 inst_pc  out  ADDR_W  PC of head instruction.
REQ-017 count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.

Function
REQ-018 FSM states: IDLE (no request), WAIT (request outstanding), DROP (outstanding request to be discarded).
REQ-019 At most one memory request outstanding at any time.
REQ-020 imem_req SHALL be 1 exactly in WAIT and DROP; imem_addr and imem_req held stable until imem_ack.
REQ-021 IDLE -> WAIT when count < DEPTH; imem_addr = fetch_pc.
REQ-022 WAIT with imem_ack: push {fetch_pc, imem_data}; fetch_pc += 4 (wraps modulo 2^ADDR_W); stay WAIT if post-update count < DEPTH, else IDLE.
REQ-023 imem_ack in the same cycle imem_req first rises is legal and completes the request.
REQ-024 Pop when inst_valid && inst_ready; inst_valid = (count != 0); inst/inst_pc from head entry.
REQ-025 Simultaneous push and pop: count unchanged, both take effect.
REQ-026 Push never occurs with count == DEPTH (guaranteed by REQ-021/022); pop never occurs with count == 0.
REQ-027 redirect: next edge count = 0, fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}; any same-cycle push or pop is discarded.
REQ-028 redirect in IDLE -> IDLE; in WAIT without ack -> DROP; in WAIT or DROP with same-cycle ack -> IDLE (data discarded).
REQ-029 DROP with imem_ack: data discarded, no push -> IDLE; then REQ-021 issues the fetch at the redirect address.
REQ-030 redirect in DROP: fetch_pc updated to the newest redirect_pc; remain DROP.
REQ-031 Read and write pointers wrap modulo DEPTH.

Reset
REQ-032 reset low asynchronously forces: state IDLE, imem_req 0, imem_addr RESET_PC, fetch_pc RESET_PC, count 0, inst_valid 0, pointers 0.
REQ-033 Reset asserted mid-request abandons it; a late imem_ack after release and before the first new request is ignored.
REQ-034 First imem_req rises on the first rising edge after reset deasserts.

Configuration
REQ-035 Macro IFQ_BYPASS_EN: when defined, with count == 0, WAIT, imem_ack and no redirect, inst_valid = 1 combinationally in the ack cycle, inst = imem_data, inst_pc = imem_addr; if inst_ready is also 1, the word is consumed and not pushed.
REQ-036 Without IFQ_BYPASS_EN, instructions appear on inst_valid no earlier than the cycle after the ack; all outputs are registered or decoded from registered state.

Verification
REQ-037 Reset release, memory acks every request in 1 cycle, inst_ready=1: inst_pc sequence 0x0, 0x4, 0x8, 0xC; one instruction per cycle in steady state.
REQ-038 inst_ready=0, DEPTH=4: after 4 acks count=4, imem_req=0; raising inst_ready for 1 cycle -> count=3, imem_req=1 on the next edge.
REQ-039 Redirect to 0x103 while WAIT with ack 3 cycles later: ack data dropped, next imem_addr=0x100, first inst_pc=0x100, count=0 until its ack.
REQ-040 Redirect coincident with ack and pop at count=2: next cycle count=0, state IDLE, then imem_addr=redirect target.
REQ-041 fetch_pc=0xFFFFFFFC, ack: next imem_addr=0x00000000.
REQ-042 With IFQ_BYPASS_EN, empty queue, ack with data 0x2408000A, inst_ready=1: inst=0x2408000A in the same cycle, count stays 0; without the macro it appears one cycle later with count=1.
